// File: rtl/ifetch_pkg.sv
// Shared encodings for the miniRV-1 instruction fetch unit: FSM states,
// fault cause codes and the default reset vector.
package ifetch_pkg;

    typedef enum logic [2:0] {
        IF_RESET = 3'd0,
        IF_REQ   = 3'd1,
        IF_WAIT  = 3'd2,
        IF_VALID = 3'd3,
        IF_FAULT = 3'd4
    } if_state_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_BUSERR   = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_instret_cnt.sv
// Retired-instruction counter: 32-bit, synchronous reset, wraps to zero.
module ifetch_instret_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] count
);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples its inputs as they were before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 32'd0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, fetches over req/gnt/rvalid and hands
// each instruction to execute under valid/ready, committing npc_i on accept.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IMEM_AW  = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic [31:0]        pc_o,
    input  logic [31:0]        npc_i,
    output logic               imem_req_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [31:0]        imem_rdata_i,
    input  logic               imem_err_i,
    output logic [31:0]        inst_o,
    output logic [31:0]        inst_pc_o,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic               fault_o,
    output logic [1:0]         fault_cause_o,
    output logic [31:0]        instret_o
);

    if_state_e   state;
    if_state_e   next_state;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  fault_cause;
    logic        commit;
    logic        resp_ok;
    logic        resp_err;

    assign commit   = (state == IF_VALID) && inst_ready_i;
    assign resp_ok  = (state == IF_WAIT) && imem_rvalid_i && !imem_err_i;
    assign resp_err = (state == IF_WAIT) && imem_rvalid_i && imem_err_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IF_RESET;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every always_comb output gets a default before the case so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IF_RESET: next_state = IF_REQ;
            IF_REQ:   if (imem_gnt_i) next_state = IF_WAIT;
            IF_WAIT:  if (imem_rvalid_i) next_state = imem_err_i ? IF_FAULT : IF_VALID;
            IF_VALID: if (inst_ready_i) next_state = is_misaligned(npc_i) ? IF_FAULT : IF_REQ;
            IF_FAULT: next_state = IF_FAULT;
            default:  next_state = IF_RESET;
        endcase
    end

    always_comb begin
        imem_req_o   = 1'b0;
        inst_valid_o = 1'b0;
        fault_o      = 1'b0;
        case (state)
            IF_REQ:   imem_req_o   = 1'b1;
            IF_VALID: inst_valid_o = 1'b1;
            IF_FAULT: fault_o      = 1'b1;
            default:  ;
        endcase
    end

    // A misaligned next PC is never committed, so pc keeps the faulting PC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc          <= RESET_PC;
            inst        <= 32'd0;
            fault_cause <= FAULT_NONE;
        end else begin
            if (resp_ok) begin
                inst <= imem_rdata_i;
            end
            if (resp_err) begin
                fault_cause <= FAULT_BUSERR;
            end
            if (commit) begin
                if (is_misaligned(npc_i)) begin
                    fault_cause <= FAULT_MISALIGN;
                end else begin
                    pc <= npc_i;
                end
            end
        end
    end

    ifetch_instret_cnt u_instret (
        .clk   (clk_i),
        .rst   (rst_i),
        .en    (commit),
        .count (instret_o)
    );

    assign pc_o          = pc;
    assign imem_addr_o   = pc[IMEM_AW-1:0];
    assign inst_o        = inst;
    assign inst_pc_o     = pc;
    assign fault_cause_o = fault_cause;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: one task per scenario, inline comparisons against
// hand-computed values; the npc generator is modelled as pc + 4 with override.
module tb_ifetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_o;
    logic [31:0] npc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        imem_err_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        fault_o;
    logic [1:0]  fault_cause_o;
    logic [31:0] instret_o;

    logic        npc_override;
    logic [31:0] npc_forced;

    int tests = 0;
    int fails = 0;

    localparam logic [165:0] RESET_VEC = {32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};

    assign npc_i = npc_override ? npc_forced : pc_o + 32'd4;

    always #5 clk_i = ~clk_i;

    ifetch dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pc_o          (pc_o),
        .npc_i         (npc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .imem_err_i    (imem_err_i),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .fault_o       (fault_o),
        .fault_cause_o (fault_cause_o),
        .instret_o     (instret_o)
    );

    function automatic logic [165:0] out_vec();
        return {pc_o, imem_addr_o, inst_pc_o, inst_o, inst_valid_o, imem_req_o,
                fault_o, fault_cause_o, instret_o};
    endfunction

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        imem_err_i    = 1'b0;
        inst_ready_i  = 1'b0;
        npc_override  = 1'b0;
        npc_forced    = 32'h0;
    endtask

    // Leaves the DUT at the first REQ cycle (cycle 1 after reset release).
    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    // From a REQ cycle: gnt at once, rvalid the next cycle; returns in VALID.
    task automatic run_to_valid(input logic [31:0] data);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        tick();
        imem_rvalid_i = 1'b0;
    endtask

    task automatic commit(input logic [31:0] npc);
        npc_override = 1'b1;
        npc_forced   = npc;
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        tests++;
        if (out_vec() !== RESET_VEC) begin
            fails++;
            $display("FAIL reset_values: got %h expected %h", out_vec(), RESET_VEC);
        end
        rst_i = 1'b0;
        tick();
        tests++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL reset_first_req: req/addr got %b/%h expected 1/00000000", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_basic_loop();
        do_reset();
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0000_0013;
        inst_ready_i  = 1'b1;
        tests++;
        if ({imem_req_o, imem_addr_o, inst_valid_o} !== {1'b1, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL basic_c1: req/addr/valid got %b/%h/%b expected 1/00000000/0", imem_req_o, imem_addr_o, inst_valid_o);
        end
        tick();
        tests++;
        if ({imem_req_o, inst_valid_o} !== 2'b00) begin
            fails++;
            $display("FAIL basic_c2: req/valid got %b/%b expected 0/0", imem_req_o, inst_valid_o);
        end
        tick();
        tests++;
        if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, 32'h0000_0013, 32'h0}) begin
            fails++;
            $display("FAIL basic_c3: valid/inst/inst_pc got %b/%h/%h expected 1/00000013/00000000", inst_valid_o, inst_o, inst_pc_o);
        end
        tick();
        tests++;
        if ({pc_o, imem_addr_o, imem_req_o, inst_valid_o, instret_o} !== {32'h4, 32'h4, 1'b1, 1'b0, 32'd1}) begin
            fails++;
            $display("FAIL basic_c4: pc/addr/req/valid/instret got %h/%h/%b/%b/%0d expected 00000004/00000004/1/0/1",
                     pc_o, imem_addr_o, imem_req_o, inst_valid_o, instret_o);
        end
        clear_inputs();
    endtask

    task automatic test_gnt_stall();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({imem_req_o, imem_addr_o, inst_valid_o} !== {1'b1, 32'h0, 1'b0}) begin
                fails++;
                $display("FAIL gnt_stall_%0d: req/addr/valid got %b/%h/%b expected 1/00000000/0", i, imem_req_o, imem_addr_o, inst_valid_o);
            end
            if (i < 4) tick();
        end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0BAD_F00D;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({imem_req_o, inst_valid_o} !== 2'b00) begin
                fails++;
                $display("FAIL rvalid_wait_%0d: req/valid got %b/%b expected 0/0", i, imem_req_o, inst_valid_o);
            end
            if (i < 2) begin
                imem_rvalid_i = 1'b0;
                tick();
            end
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hA5A5_0093;
        tick();
        imem_rvalid_i = 1'b0;
        tests++;
        if ({inst_valid_o, inst_o} !== {1'b1, 32'hA5A5_0093}) begin
            fails++;
            $display("FAIL gnt_stall_valid: valid/inst got %b/%h expected 1/a5a50093", inst_valid_o, inst_o);
        end
        clear_inputs();
    endtask

    task automatic test_ready_stall();
        do_reset();
        run_to_valid(32'h0010_0093);
        npc_override  = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            npc_forced = 32'h100 + 32'(i * 4);
            tests++;
            if ({inst_valid_o, inst_o, inst_pc_o, pc_o, instret_o} !== {1'b1, 32'h0010_0093, 32'h0, 32'h0, 32'd0}) begin
                fails++;
                $display("FAIL ready_stall_%0d: valid/inst/inst_pc/pc/instret got %b/%h/%h/%h/%0d expected 1/00100093/00000000/00000000/0",
                         i, inst_valid_o, inst_o, inst_pc_o, pc_o, instret_o);
            end
            tick();
        end
        imem_rvalid_i = 1'b0;
        commit(32'h40);
        tests++;
        if ({pc_o, imem_addr_o, imem_req_o, inst_valid_o, instret_o} !== {32'h40, 32'h40, 1'b1, 1'b0, 32'd1}) begin
            fails++;
            $display("FAIL ready_commit: pc/addr/req/valid/instret got %h/%h/%b/%b/%0d expected 00000040/00000040/1/0/1",
                     pc_o, imem_addr_o, imem_req_o, inst_valid_o, instret_o);
        end
        npc_forced = 32'h80;
        tick();
        tests++;
        if ({pc_o, instret_o} !== {32'h40, 32'd1}) begin
            fails++;
            $display("FAIL ready_single_update: pc/instret got %h/%0d expected 00000040/1", pc_o, instret_o);
        end
        clear_inputs();
    endtask

    task automatic test_misalign();
        do_reset();
        run_to_valid(32'h0000_0013);
        commit(32'h10);
        run_to_valid(32'h0000_0013);
        tests++;
        if ({inst_valid_o, inst_pc_o} !== {1'b1, 32'h10}) begin
            fails++;
            $display("FAIL misalign_setup: valid/inst_pc got %b/%h expected 1/00000010", inst_valid_o, inst_pc_o);
        end
        commit(32'h0000_0102);
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b1;
        inst_ready_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({fault_o, fault_cause_o, pc_o, imem_req_o, inst_valid_o} !== {1'b1, 2'b01, 32'h10, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL misalign_%0d: fault/cause/pc/req/valid got %b/%b/%h/%b/%b expected 1/01/00000010/0/0",
                         i, fault_o, fault_cause_o, pc_o, imem_req_o, inst_valid_o);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_bus_error();
        do_reset();
        run_to_valid(32'h0000_0013);
        commit(32'h20);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_err_i    = 1'b1;
        imem_rdata_i  = 32'h1234_5678;
        tick();
        imem_rvalid_i = 1'b0;
        imem_err_i    = 1'b0;
        tests++;
        if ({fault_o, fault_cause_o, pc_o, instret_o, imem_req_o, inst_valid_o} !== {1'b1, 2'b10, 32'h20, 32'd1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL bus_error: fault/cause/pc/instret/req/valid got %b/%b/%h/%0d/%b/%b expected 1/10/00000020/1/0/0",
                     fault_o, fault_cause_o, pc_o, instret_o, imem_req_o, inst_valid_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        npc_override = 1'b0;
        tests++;
        if (out_vec() !== RESET_VEC) begin
            fails++;
            $display("FAIL bus_error_reset: got %h expected %h", out_vec(), RESET_VEC);
        end
        tick();
        tests++;
        if ({imem_req_o, imem_addr_o, fault_o} !== {1'b1, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL bus_error_restart: req/addr/fault got %b/%h/%b expected 1/00000000/0", imem_req_o, imem_addr_o, fault_o);
        end
        clear_inputs();
    endtask

    task automatic test_instret_wrap();
        do_reset();
        run_to_valid(32'h0000_0013);
        force dut.u_instret.count = 32'hFFFF_FFFF;
        #1;
        release dut.u_instret.count;
        commit(32'h4);
        tests++;
        if ({instret_o, pc_o} !== {32'h0, 32'h4}) begin
            fails++;
            $display("FAIL instret_wrap: instret/pc got %h/%h expected 00000000/00000004", instret_o, pc_o);
        end
        clear_inputs();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        rst_i      = 1'b1;
        tick();
        rst_i         = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0000_0013;
        tests++;
        if ({inst_valid_o, imem_req_o, inst_o} !== {1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL reset_wait_rst: valid/req/inst got %b/%b/%h expected 0/0/00000000", inst_valid_o, imem_req_o, inst_o);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if ({inst_valid_o, imem_req_o, inst_o} !== {1'b0, 1'b1, 32'h0}) begin
                fails++;
                $display("FAIL reset_wait_late_rvalid_%0d: valid/req/inst got %b/%b/%h expected 0/1/00000000", i, inst_valid_o, imem_req_o, inst_o);
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        test_reset();
        test_basic_loop();
        test_gnt_stall();
        test_ready_stall();
        test_misalign();
        test_bus_error();
        test_instret_wrap();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
